// File: rtl/sbox_2om_array.sv
// Array of second-order (three-share) masked AES S-boxes with a shared valid pipeline,
// guard-seed chaining across lanes, flush and sticky randomness-starvation error.

module sbox_2om_core #(
  parameter int CORE_LAT = 8  // >= 4: four compute stages, the rest is alignment delay
) (
  input  logic         clk,
  input  logic [7:0]   x1,
  input  logic [7:0]   x2,
  input  logic [7:0]   x3,
  input  logic [131:0] rnd,
  input  logic [7:0]   guard_in,
  output logic [7:0]   guard_out,
  output logic [7:0]   y1,
  output logic [7:0]   y2,
  output logic [7:0]   y3
);

  typedef logic [2:0][7:0] shares_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Squaring is linear over GF(2^8), so it is applied to each share independently.
  function automatic shares_t sh_pow2n(input shares_t a, input int n);
    shares_t c;
    c = a;
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < n; k++)
        c[s] = gf_mul(c[s], c[s]);
    return c;
  endfunction

  function automatic shares_t refresh(input shares_t a, input logic [15:0] r);
    shares_t c;
    c[0] = a[0] ^ r[7:0];
    c[1] = a[1] ^ r[15:8];
    c[2] = a[2] ^ r[7:0] ^ r[15:8];
    return c;
  endfunction

  // ISW multiplication; the brackets fix the order in which cross products meet randomness.
  function automatic shares_t isw_mul(input shares_t a, input shares_t b, input logic [23:0] r);
    shares_t c;
    c[0] = gf_mul(a[0], b[0]) ^ r[7:0] ^ r[15:8];
    c[1] = gf_mul(a[1], b[1]) ^ (r[7:0] ^ gf_mul(a[0], b[1]) ^ gf_mul(a[1], b[0])) ^ r[23:16];
    c[2] = gf_mul(a[2], b[2]) ^ (r[15:8] ^ gf_mul(a[0], b[2]) ^ gf_mul(a[2], b[0]))
         ^ (r[23:16] ^ gf_mul(a[1], b[2]) ^ gf_mul(a[2], b[1]));
    return c;
  endfunction

  function automatic logic [7:0] affine_lin(input logic [7:0] b);
    logic [7:0] l;
    for (int i = 0; i < 8; i++)
      l[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
    return l;
  endfunction

  shares_t x_g, x2_z, x3_c, x12_w, x15_c, x252_c, x254_c, y_c;
  shares_t s1_x2, s1_x3, s2_x2, s2_x12, s2_x15, s3_x2, s3_x252;
  shares_t pipe [CORE_LAT-3];

  // Inversion as x^254 = x^2 * x^252 via the chain x^3, x^12, x^15, x^240, x^252.
  assign x_g    = {x3 ^ guard_in, x2, x1 ^ guard_in};
  assign x2_z   = refresh(sh_pow2n(x_g, 1), rnd[15:0]);
  assign x3_c   = isw_mul(x2_z, x_g, rnd[39:16]);
  assign x12_w  = refresh(sh_pow2n(s1_x3, 2), rnd[55:40]);
  assign x15_c  = isw_mul(x12_w, s1_x3, rnd[79:56]);
  assign x252_c = isw_mul(sh_pow2n(s2_x15, 4), s2_x12, rnd[103:80]);
  assign x254_c = isw_mul(s3_x252, s3_x2, rnd[127:104]);
  assign y_c    = {affine_lin(x254_c[2]), affine_lin(x254_c[1]), affine_lin(x254_c[0]) ^ 8'h63};

  assign guard_out = {guard_in[6:0], guard_in[7]} ^ {rnd[131:128], rnd[131:128]};

  // NOTE: datapath registers carry no reset; validity is tracked by the parent's
  // reset valid pipeline, so stale share values are never observed.
  always_ff @(posedge clk) begin
    s1_x2   <= x2_z;
    s1_x3   <= x3_c;
    s2_x2   <= s1_x2;
    s2_x12  <= x12_w;
    s2_x15  <= x15_c;
    s3_x2   <= s2_x2;
    s3_x252 <= x252_c;
    pipe[0] <= y_c;
    for (int k = 1; k < CORE_LAT - 3; k++) pipe[k] <= pipe[k-1];
  end

  assign y1 = pipe[CORE_LAT-4][0];
  assign y2 = pipe[CORE_LAT-4][1];
  assign y3 = pipe[CORE_LAT-4][2];

endmodule

module sbox_2om_array #(
  parameter int NUM_SBOX = 4,
  parameter int CORE_LAT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [8*NUM_SBOX-1:0]     x1,
  input  logic [8*NUM_SBOX-1:0]     x2,
  input  logic [8*NUM_SBOX-1:0]     x3,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [132*NUM_SBOX+7:0]   rnd,
  input  logic                      rnd_valid,
  input  logic                      flush,
  input  logic                      err_clr,
  output logic [8*NUM_SBOX-1:0]     out1,
  output logic [8*NUM_SBOX-1:0]     out2,
  output logic [8*NUM_SBOX-1:0]     out3,
  output logic                      out_valid,
  output logic [4:0]                occupancy,
  output logic                      err
);

  logic [CORE_LAT:0]     vld_sr;
  logic [7:0]            guard_reg;
  logic [7:0]            guard_chain [NUM_SBOX+1];
  logic [8*NUM_SBOX-1:0] core_y1, core_y2, core_y3;
  logic                  accept, starve;
  logic [4:0]            occ_next;

  assign in_ready  = rst_n & rnd_valid & ~err & ~flush;
  assign accept    = in_valid & in_ready;
  assign starve    = ~rnd_valid & (occupancy != 5'd0);
  assign out_valid = vld_sr[CORE_LAT];
  assign guard_chain[0] = guard_reg;

  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
    sbox_2om_core #(.CORE_LAT(CORE_LAT)) u_core (
      .clk       (clk),
      .x1        (x1[8*i +: 8]),
      .x2        (x2[8*i +: 8]),
      .x3        (x3[8*i +: 8]),
      .rnd       (rnd[132*i +: 132]),
      .guard_in  (guard_chain[i]),
      .guard_out (guard_chain[i+1]),
      .y1        (core_y1[8*i +: 8]),
      .y2        (core_y2[8*i +: 8]),
      .y3        (core_y3[8*i +: 8])
    );
  end

  always_comb begin
    occ_next = occupancy;
    case ({accept, out_valid})
      2'b10:   occ_next = occupancy + 5'd1;
      2'b01:   occ_next = occupancy - 5'd1;
      default: occ_next = occupancy;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr    <= '0;
      occupancy <= '0;
      err       <= 1'b0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
    end else if (flush) begin
      vld_sr    <= '0;
      occupancy <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      if (err_clr) err <= 1'b0;
    end else if (starve) begin
      err       <= 1'b1;
      vld_sr    <= '0;
      occupancy <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
    end else begin
      vld_sr    <= {vld_sr[CORE_LAT-1:0], accept};
      occupancy <= occ_next;
      if (err_clr) err <= 1'b0;
      if (vld_sr[CORE_LAT-1]) begin
        out1 <= core_y1;
        out2 <= core_y2;
        out3 <= core_y3;
      end
    end
  end

  // A fresh seed enters only when the pipe is empty; otherwise the guard keeps circulating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              guard_reg <= 8'h00;
    else if (occupancy == 5'd0 && rnd_valid) guard_reg <= rnd[132*NUM_SBOX +: 8];
    else                                     guard_reg <= guard_chain[NUM_SBOX];
  end

endmodule
